control_sequencer: RTL

Parametrised multicycle control unit for the Mini SRC datapath: a Moore state machine that steps fetch, decode and per-class execute steps, and drives every datapath strobe. Generalisations:
- configurable opcode field, register count and link register
- wait-state memory handshake
- conditional-branch gating from CON_FF
- synchronous stop request honoured only at instruction boundaries
- retired-instruction counter

Sits between the IR/CON logic and the bus, register file, ALU, memory and I/O port enables.

---
 rtl/control_sequencer_if.sv | 38 +++
 rtl/control_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// Strobe and handshake bundle between the Mini SRC control sequencer (master)
// and the datapath it drives (slave).
interface control_sequencer_if #(
  parameter int NREG = 16,
  parameter int CNTW = 16
);
  logic [31:0]     IR;
  logic            CON_FF;
  logic            MemRdy;
  logic            Stop;

  logic            PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin;
  logic            Yin, IncPC, Read, Write, HIin, LOin, HIout, LOout;
  logic            ZhighIn, ZlowIn, Cout, Gra, Grb, Grc, Rin, Rout;
  logic            BAout, CONin, Inportin, Outportin, Inportout;
  logic [NREG-1:0] R_enableIn;
  logic            Run;
  logic            Illegal;
  logic [CNTW-1:0] InstrCount;

  modport master (
    input  IR, CON_FF, MemRdy, Stop,
    output PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin,
           Yin, IncPC, Read, Write, HIin, LOin, HIout, LOout,
           ZhighIn, ZlowIn, Cout, Gra, Grb, Grc, Rin, Rout,
           BAout, CONin, Inportin, Outportin, Inportout,
           R_enableIn, Run, Illegal, InstrCount
  );

  modport slave (
    output IR, CON_FF, MemRdy, Stop,
    input  PCout, Zhighout, Zlowout, MDRout, MARin, PCin, MDRin, IRin,
           Yin, IncPC, Read, Write, HIin, LOin, HIout, LOout,
           ZhighIn, ZlowIn, Cout, Gra, Grb, Grc, Rin, Rout,
           BAout, CONin, Inportin, Outportin, Inportout,
           R_enableIn, Run, Illegal, InstrCount
  );
endinterface

// File: rtl/control_sequencer.sv
// Mini SRC multicycle Moore control unit: fetch, decode, per-class execute steps.
// Define CTRL_MULDIV_EN to enable the mul/div sequence (otherwise those opcodes are illegal).
module control_sequencer #(
  parameter int OPW      = 5,
  parameter int NREG     = 16,
  parameter int LINK_REG = 14,
  parameter int CNTW     = 16
) (
  input logic Clock,
  input logic Reset,
  control_sequencer_if.master bus
);

  typedef enum logic [5:0] {
    RST, F0, F1, F2, DEC, HALT, ILL,
    AR3, AR4, AR5, AI3, AI4, AI5, LDI3, NN3, NN4,
    MD3, MD4, MD5, MD6,
    LD3, LD4, LD5, LD6, LD7, ST3, ST4, ST5, ST6, ST7,
    BR3, BR4, BR5, BR6, JR3, JAL3, JAL4, MFHI3, MFLO3, IN3, OUT3
  } state_t;

  state_t state_reg, state_next;
  logic   stop_pend_reg;
  logic [CNTW-1:0] count_reg;

  // Opcodes are 5-bit codes; any wider opcode with nonzero upper bits is illegal.
  localparam int OPX = (OPW > 5) ? OPW : 5;
  logic [OPX-1:0] op_x;
  logic [4:0]     op5;
  logic           op_hi_zero;

  assign op_x       = OPX'(bus.IR[31:32-OPW]);
  assign op5        = op_x[4:0];
  assign op_hi_zero = (op_x >> 5) == '0;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_reg <= RST;
    else       state_reg <= state_next;
  end

  // A stop request is remembered until the next instruction boundary.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)         stop_pend_reg <= 1'b0;
    else if (bus.Stop) stop_pend_reg <= 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)
      count_reg <= '0;
    else if (state_next == F0 && state_reg != RST)
      count_reg <= count_reg + CNTW'(1);
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST:  state_next = F0;
      F0:   state_next = (bus.Stop || stop_pend_reg) ? HALT : F1;
      F1:   state_next = bus.MemRdy ? F2 : F1;
      F2:   state_next = DEC;
      DEC: begin
        if (!op_hi_zero) state_next = ILL;
        else begin
          case (op5)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: state_next = AR3;
            5'b01100, 5'b01101, 5'b01110:           state_next = AI3;
            5'b00001:                               state_next = LDI3;
            5'b10001, 5'b10010:                     state_next = NN3;
`ifdef CTRL_MULDIV_EN
            5'b01111, 5'b10000:                     state_next = MD3;
`endif
            5'b00000: state_next = LD3;
            5'b00010: state_next = ST3;
            5'b10011: state_next = BR3;
            5'b10100: state_next = JR3;
            5'b10101: state_next = JAL3;
            5'b11000: state_next = MFHI3;
            5'b11001: state_next = MFLO3;
            5'b10110: state_next = IN3;
            5'b10111: state_next = OUT3;
            5'b11010: state_next = F0;
            5'b11011: state_next = HALT;
            default:  state_next = ILL;
          endcase
        end
      end
      HALT: state_next = HALT;
      ILL:  state_next = F0;
      AR3:  state_next = AR4;
      AR4:  state_next = AR5;
      AI3, LDI3: state_next = AI4;
      AI4:  state_next = AI5;
      NN3:  state_next = NN4;
      MD3:  state_next = MD4;
      MD4:  state_next = MD5;
      MD5:  state_next = MD6;
      LD3:  state_next = LD4;
      LD4:  state_next = LD5;
      LD5:  state_next = LD6;
      LD6:  state_next = bus.MemRdy ? LD7 : LD6;
      ST3:  state_next = ST4;
      ST4:  state_next = ST5;
      ST5:  state_next = ST6;
      ST6:  state_next = ST7;
      ST7:  state_next = bus.MemRdy ? F0 : ST7;
      BR3:  state_next = BR4;
      BR4:  state_next = BR5;
      BR5:  state_next = BR6;
      JAL3: state_next = JAL4;
      AR5, AI5, NN4, MD6, LD7, BR6, JR3, JAL4, MFHI3, MFLO3, IN3, OUT3:
            state_next = F0;
      default: state_next = RST;
    endcase
  end

  always_comb begin
    bus.PCout     = state_reg inside {F0, BR4, JAL3};
    bus.Zlowout   = state_reg inside {F1, AR5, AI5, NN4, MD5, LD5, ST5, BR6};
    bus.MDRout    = state_reg inside {F2, LD7, ST7};
    bus.MARin     = state_reg inside {F0, LD5, ST5};
    bus.PCin      = (state_reg inside {F1, JR3, JAL4}) || (state_reg == BR6 && bus.CON_FF);
    bus.MDRin     = state_reg inside {F1, LD6, ST6};
    bus.IRin      = state_reg == F2;
    bus.Yin       = state_reg inside {AR3, AI3, LDI3, MD3, LD3, ST3, BR4};
    bus.IncPC     = state_reg == F0;
    bus.Read      = state_reg inside {F1, LD6};
    bus.Write     = state_reg == ST7;
`ifdef CTRL_MULDIV_EN
    bus.Zhighout  = state_reg == MD6;
    bus.HIin      = state_reg == MD6;
    bus.LOin      = state_reg == MD5;
`else
    bus.Zhighout  = 1'b0;
    bus.HIin      = 1'b0;
    bus.LOin      = 1'b0;
`endif
    bus.HIout     = state_reg == MFHI3;
    bus.LOout     = state_reg == MFLO3;
    bus.ZlowIn    = state_reg inside {F0, AR4, AI4, NN3, MD4, LD4, ST4, BR5};
    bus.ZhighIn   = bus.ZlowIn;
    bus.Cout      = state_reg inside {AI4, LD4, ST4, BR5};
    bus.Gra       = state_reg inside {AR5, AI5, NN4, MD3, LD7, ST6, BR3, JR3, JAL4,
                                      MFHI3, MFLO3, IN3, OUT3};
    bus.Grb       = state_reg inside {AR3, AI3, LDI3, NN3, MD4, LD3, ST3};
    bus.Grc       = state_reg == AR4;
    bus.Rin       = state_reg inside {AR5, AI5, NN4, LD7, MFHI3, MFLO3, IN3};
    bus.Rout      = state_reg inside {AR3, AR4, AI3, NN3, MD3, MD4, ST6, BR3, JR3, JAL4, OUT3};
    bus.BAout     = state_reg inside {LDI3, LD3, ST3};
    bus.CONin     = state_reg == BR3;
    bus.Inportin  = 1'b0;
    bus.Outportin = state_reg == OUT3;
    bus.Inportout = state_reg == IN3;
    bus.Run       = state_reg != HALT;
    bus.Illegal   = state_reg == ILL;
  end

  // jal writes the return address straight into the link register.
  for (genvar gi = 0; gi < NREG; gi++) begin : g_ren
    assign bus.R_enableIn[gi] = (gi == LINK_REG) && (state_reg == JAL3);
  end

  assign bus.InstrCount = count_reg;

endmodule
